// File: rtl/gerador_asteroide.sv
// gerador_asteroide: spawns new asteroid entries (x, y, opcode) on the border of
// the 16x16 field, heading inward, avoiding the ship's cell.
// Optional debug outputs are enabled with the ASTE_GERADOR_DB_EN macro.
//
// Ports:
//   clock, reset         rising-edge clock, async active-high reset
//   pede_aste            spawn request (sampled in OCIOSO)
//   aceito               consumer accepted the entry (sampled in VALIDO)
//   nave_coor_x/y        ship coordinates, compared while in CHECA
//   carrega_semente      load semente into the LFSR (0 selects SEED)
//   semente              seed value
//   random_x/y/opcode    latched entry; qualify with valido
//   valido               entry valid
//   pronto               idle, ready for a request
//   db_estado, db_lfsr   (ASTE_GERADOR_DB_EN only) state and LFSR snapshot
module gerador_asteroide #(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int unsigned MAX_TENT = 3,
  parameter int unsigned COOLDOWN = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pede_aste,
  input  logic        aceito,
  input  logic [3:0]  nave_coor_x,
  input  logic [3:0]  nave_coor_y,
  input  logic        carrega_semente,
  input  logic [15:0] semente,
  output logic [3:0]  random_x,
  output logic [3:0]  random_y,
  output logic [1:0]  random_opcode,
  output logic        valido,
  output logic        pronto
`ifdef ASTE_GERADOR_DB_EN
  ,
  output logic [1:0]  db_estado,
  output logic [15:0] db_lfsr
`endif
);

  localparam int unsigned TENT_W = 4;
  localparam int unsigned CONT_W = 8;
  localparam logic [TENT_W-1:0] MAX_TENT_L = TENT_W'(MAX_TENT);
  localparam logic [CONT_W-1:0] COOLDOWN_L = CONT_W'(COOLDOWN);

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    CHECA  = 2'b01,
    VALIDO = 2'b10,
    ESPERA = 2'b11
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [TENT_W-1:0]   tent_q, tent_d;
  logic [CONT_W-1:0]   cont_q, cont_d;
  logic [3:0]          x_d, y_d;
  logic [1:0]          op_d;
  logic                valido_d, pronto_d;
  logic [3:0]          cand_x, cand_y;
  logic [1:0]          cand_op;
  logic [3:0]          pos;
  logic                colide;

  // LFSR next value; a zero seed would lock the LFSR, so it selects SEED
  always_comb begin
    if (carrega_semente) begin
      lfsr_d = (semente == 16'h0000) ? SEED : semente;
    end else begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // Border candidate from the current LFSR: side picks the edge and heading
  always_comb begin
    pos     = lfsr_q[5:2];
    cand_op = lfsr_q[1:0];
    cand_x  = 4'd0;
    cand_y  = 4'd0;
    case (lfsr_q[1:0])
      2'b00: begin cand_x = 4'd0;  cand_y = pos;   end
      2'b01: begin cand_x = 4'd15; cand_y = pos;   end
      2'b10: begin cand_x = pos;   cand_y = 4'd0;  end
      default: begin cand_x = pos; cand_y = 4'd15; end
    endcase
  end

  assign colide = (random_x == nave_coor_x) && (random_y == nave_coor_y);

  // Next-state and next-output logic
  always_comb begin
    estado_d = estado_q;
    tent_d   = tent_q;
    cont_d   = cont_q;
    x_d      = random_x;
    y_d      = random_y;
    op_d     = random_opcode;

    case (estado_q)
      OCIOSO: begin
        if (pede_aste) begin
          x_d      = cand_x;
          y_d      = cand_y;
          op_d     = cand_op;
          tent_d   = '0;
          estado_d = CHECA;
        end
      end
      CHECA: begin
        if (!colide) begin
          estado_d = VALIDO;
        end else if (tent_q < MAX_TENT_L) begin
          x_d    = cand_x;
          y_d    = cand_y;
          op_d   = cand_op;
          tent_d = tent_q + TENT_W'(1);
        end else begin
          // Out of retries: mirror through the centre, which keeps the entry
          // on the opposite border heading inward; not rechecked.
          x_d      = 4'd15 - random_x;
          y_d      = 4'd15 - random_y;
          op_d     = random_opcode ^ 2'b01;
          estado_d = VALIDO;
        end
      end
      VALIDO: begin
        if (aceito) begin
          if (COOLDOWN_L == '0) begin
            estado_d = OCIOSO;
          end else begin
            cont_d   = COOLDOWN_L;
            estado_d = ESPERA;
          end
        end
      end
      ESPERA: begin
        if (cont_q <= CONT_W'(1)) begin
          estado_d = OCIOSO;
        end else begin
          cont_d = cont_q - CONT_W'(1);
        end
      end
      default: estado_d = OCIOSO;
    endcase

    valido_d = (estado_d == VALIDO);
    pronto_d = (estado_d == OCIOSO);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q      <= OCIOSO;
      lfsr_q        <= SEED;
      tent_q        <= '0;
      cont_q        <= '0;
      random_x      <= '0;
      random_y      <= '0;
      random_opcode <= '0;
      valido        <= 1'b0;
      pronto        <= 1'b1;
    end else begin
      estado_q      <= estado_d;
      lfsr_q        <= lfsr_d;
      tent_q        <= tent_d;
      cont_q        <= cont_d;
      random_x      <= x_d;
      random_y      <= y_d;
      random_opcode <= op_d;
      valido        <= valido_d;
      pronto        <= pronto_d;
    end
  end

`ifdef ASTE_GERADOR_DB_EN
  assign db_estado = estado_q;
  assign db_lfsr   = lfsr_q;
`endif

endmodule

// File: tb/tb_gerador_asteroide.sv
// Self-checking bench for gerador_asteroide: table-driven spawn vectors with a
// scoreboard queue, plus hand sequences for fallback, cooldown and reset.
module tb_gerador_asteroide;

  localparam int COOL = 4;

  logic        clock;
  logic        reset;
  logic        pede_aste;
  logic        aceito;
  logic [3:0]  nave_coor_x;
  logic [3:0]  nave_coor_y;
  logic        carrega_semente;
  logic [15:0] semente;
  logic [3:0]  rx, ry, rx2, ry2;
  logic [1:0]  rop, rop2;
  logic        val, pr, val2, pr2;
`ifdef ASTE_GERADOR_DB_EN
  logic [1:0]  db_est, db_est2;
  logic [15:0] db_lf, db_lf2;
`endif

  gerador_asteroide #(.SEED(16'hACE1), .MAX_TENT(3), .COOLDOWN(COOL)) dut (
    .clock(clock), .reset(reset), .pede_aste(pede_aste), .aceito(aceito),
    .nave_coor_x(nave_coor_x), .nave_coor_y(nave_coor_y),
    .carrega_semente(carrega_semente), .semente(semente),
    .random_x(rx), .random_y(ry), .random_opcode(rop),
    .valido(val), .pronto(pr)
`ifdef ASTE_GERADOR_DB_EN
    , .db_estado(db_est), .db_lfsr(db_lf)
`endif
  );

  // Zero-retry variant for the fallback path; shares all inputs
  gerador_asteroide #(.SEED(16'hACE1), .MAX_TENT(0), .COOLDOWN(COOL)) dut2 (
    .clock(clock), .reset(reset), .pede_aste(pede_aste), .aceito(aceito),
    .nave_coor_x(nave_coor_x), .nave_coor_y(nave_coor_y),
    .carrega_semente(carrega_semente), .semente(semente),
    .random_x(rx2), .random_y(ry2), .random_opcode(rop2),
    .valido(val2), .pronto(pr2)
`ifdef ASTE_GERADOR_DB_EN
    , .db_estado(db_est2), .db_lfsr(db_lf2)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] seed;
    logic [3:0]  nx, ny;
    logic [3:0]  ex, ey;
    logic [1:0]  eop;
    int          retries;
    int          hold;
  } vec_t;

  typedef struct {
    logic [3:0] x, y;
    logic [1:0] op;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait for valido (bounded), then pop the scoreboard and compare
  task automatic wait_and_score(input string tag);
    int   n;
    bit   found;
    exp_t e;
    n = 0;
    found = 1'b0;
    while (n < 20 && !found) begin
      tick();
      n++;
      if (val) found = 1'b1;
    end
    e = sb.pop_front();
    if (!found) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: valido never rose, expected after %0d edges", tag, e.lat);
    end else begin
      check({tag, "_x"},   32'(rx),  32'(e.x));
      check({tag, "_y"},   32'(ry),  32'(e.y));
      check({tag, "_op"},  32'(rop), 32'(e.op));
      check({tag, "_lat"}, 32'(n),   32'(e.lat));
    end
  endtask

  // Accept and verify the cooldown window, ending back in OCIOSO
  task automatic accept_and_drain(input string tag);
    aceito = 1'b1;
    tick();
    aceito = 1'b0;
    check({tag, "_val_after_acc"}, 32'(val), 32'd0);
    for (int i = 0; i < COOL; i++) begin
      check({tag, "_pronto_cool"}, 32'(pr), 32'd0);
      tick();
    end
    check({tag, "_pronto_back"}, 32'(pr), 32'd1);
  endtask

  task automatic run_spawn(input vec_t v, input string tag);
    carrega_semente = 1'b1;
    semente         = v.seed;
    nave_coor_x     = v.nx;
    nave_coor_y     = v.ny;
    tick();
    carrega_semente = 1'b0;
    check({tag, "_pronto_idle"}, 32'(pr), 32'd1);
    pede_aste = 1'b1;
    sb.push_back('{x: v.ex, y: v.ey, op: v.eop, lat: 1 + v.retries});
    tick();
    pede_aste = 1'b0;
    check({tag, "_pronto_checa"}, 32'(pr), 32'd0);
    wait_and_score(tag);
    for (int i = 0; i < v.hold; i++) begin
      tick();
      check({tag, "_hold_val"}, 32'(val), 32'd1);
      check({tag, "_hold_xyop"}, {22'd0, rx, ry, rop}, {22'd0, v.ex, v.ey, v.eop});
    end
    accept_and_drain(tag);
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{seed: 16'h0004, nx: 4'd7,  ny: 4'd7, ex: 4'd0,  ey: 4'd1,  eop: 2'b00, retries: 0, hold: 0};
    vecs[1] = '{seed: 16'h0004, nx: 4'd0,  ny: 4'd1, ex: 4'd0,  ey: 4'd2,  eop: 2'b00, retries: 1, hold: 0};
    vecs[2] = '{seed: 16'h0016, nx: 4'd7,  ny: 4'd7, ex: 4'd5,  ey: 4'd0,  eop: 2'b10, retries: 0, hold: 10};
    vecs[3] = '{seed: 16'h00FF, nx: 4'd3,  ny: 4'd3, ex: 4'd15, ey: 4'd15, eop: 2'b11, retries: 0, hold: 0};
    vecs[4] = '{seed: 16'h0001, nx: 4'd15, ny: 4'd0, ex: 4'd0,  ey: 4'd0,  eop: 2'b10, retries: 1, hold: 0};
    vecs[5] = '{seed: 16'h0016, nx: 4'd5,  ny: 4'd0, ex: 4'd0,  ey: 4'd11, eop: 2'b00, retries: 1, hold: 0};
    vecs[6] = '{seed: 16'h0000, nx: 4'd7,  ny: 4'd7, ex: 4'd15, ey: 4'd8,  eop: 2'b01, retries: 0, hold: 0};

    reset = 1'b1;
    pede_aste = 1'b0;
    aceito = 1'b0;
    nave_coor_x = 4'd7;
    nave_coor_y = 4'd7;
    carrega_semente = 1'b0;
    semente = 16'h0000;
    tick();
    tick();
    check("rst_valido", 32'(val), 32'd0);
    check("rst_pronto", 32'(pr), 32'd1);
    check("rst_xyop", {22'd0, rx, ry, rop}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_spawn(vecs[i], $sformatf("vec%0d", i));

    // Fallback: the zero-retry instance mirrors the rejected candidate
    carrega_semente = 1'b1;
    semente = 16'h0004;
    nave_coor_x = 4'd0;
    nave_coor_y = 4'd1;
    tick();
    carrega_semente = 1'b0;
    pede_aste = 1'b1;
    tick();
    pede_aste = 1'b0;
    tick();
    check("fb_valido", 32'(val2), 32'd1);
    check("fb_xyop", {22'd0, rx2, ry2, rop2}, {22'd0, 4'd15, 4'd14, 2'b01});
    tick();
    check("fb_main_xyop", {22'd0, rx, ry, rop}, {22'd0, 4'd0, 4'd2, 2'b00});
    accept_and_drain("fb");

    // Request held through ESPERA is ignored until OCIOSO; seed reloaded mid-cooldown
    carrega_semente = 1'b1;
    semente = 16'h0016;
    nave_coor_x = 4'd7;
    nave_coor_y = 4'd7;
    tick();
    carrega_semente = 1'b0;
    pede_aste = 1'b1;
    tick();
    pede_aste = 1'b0;
    tick();
    check("cd_first_val", 32'(val), 32'd1);
    aceito = 1'b1;
    pede_aste = 1'b1;
    tick();                               // edge a: accepted
    aceito = 1'b0;
    carrega_semente = 1'b1;
    semente = 16'h0004;
    tick();                               // edge a+1: seed load in ESPERA
    carrega_semente = 1'b0;
    check("cd_pronto_a1", 32'(pr), 32'd0);
    tick();
    check("cd_pronto_a2", 32'(pr), 32'd0);
    tick();
    check("cd_pronto_a3", 32'(pr), 32'd0);
    check("cd_valido_a3", 32'(val), 32'd0);
    tick();
    check("cd_pronto_a4", 32'(pr), 32'd1);
    sb.push_back('{x: 4'd0, y: 4'd8, op: 2'b00, lat: 1});
    tick();                               // edge a+5: request sampled
    pede_aste = 1'b0;
    check("cd_pronto_a5", 32'(pr), 32'd0);
    wait_and_score("cd");
    accept_and_drain("cd2");

    // Reset mid-VALIDO clears immediately; LFSR restarts from SEED
    carrega_semente = 1'b1;
    semente = 16'h0016;
    tick();
    carrega_semente = 1'b0;
    pede_aste = 1'b1;
    tick();
    pede_aste = 1'b0;
    tick();
    check("mr_val_before", 32'(val), 32'd1);
    reset = 1'b1;
    #1;
    check("mr_valido", 32'(val), 32'd0);
    check("mr_pronto", 32'(pr), 32'd1);
    check("mr_xyop", {22'd0, rx, ry, rop}, 32'd0);
`ifdef ASTE_GERADOR_DB_EN
    check("mr_lfsr", 32'(db_lf), 32'h0000ACE1);
`endif
    tick();
    reset = 1'b0;
    pede_aste = 1'b1;
    sb.push_back('{x: 4'd15, y: 4'd8, op: 2'b01, lat: 1});
    tick();
    pede_aste = 1'b0;
    wait_and_score("mr");
    accept_and_drain("mr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
